// File: rtl/serial_frame_tx_if.sv
// Parallel-word handshake bundle for serial_frame_tx.
// The master offers data_in with load; the slave answers with ready.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              ready;

    modport master (output data_in, output load, input ready);
    modport slave  (input data_in, input load, output ready);
endinterface

// File: rtl/serial_frame_tx.sv
// Bit-serial frame transmitter: start, data LSB-first, optional even parity, stop.
// All outputs decode from registered state, so load/data_in never reach them combinationally.
module serial_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int BIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    serial_frame_tx_if.slave  bus,
    output logic              x_out,
    output logic              busy,
    output logic              done
);

    localparam int CW = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES + 1);
    localparam int BW = (DATA_W < 2) ? 1 : $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [BW-1:0] B_ONE    = BW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cyc, cyc_n;
    logic [BW-1:0]     bitc, bitc_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              par, par_n;
    logic              done_q, done_n;
    logic              tick;

    // State, counters, shift register and done pulse register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            cyc    <= '0;
            bitc   <= '0;
            sh     <= '0;
            par    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cyc    <= cyc_n;
            bitc   <= bitc_n;
            sh     <= sh_n;
            par    <= par_n;
            done_q <= done_n;
        end
    end

    assign tick = (cyc == CYC_LAST);

    // Next-state: each bit lasts BIT_CYCLES; counters clear on every state change
    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        bitc_n  = bitc;
        sh_n    = sh;
        par_n   = par;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                cyc_n  = '0;
                bitc_n = '0;
                if (bus.load) begin
                    sh_n    = bus.data_in;
                    par_n   = ^bus.data_in;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    cyc_n   = '0;
                    state_n = DATA;
                end else begin
                    cyc_n = cyc + C_ONE;
                end
            end
            DATA: begin
                if (tick) begin
                    cyc_n = '0;
                    sh_n  = sh >> 1;
                    if (bitc == BIT_LAST) begin
                        bitc_n  = '0;
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitc_n = bitc + B_ONE;
                    end
                end else begin
                    cyc_n = cyc + C_ONE;
                end
            end
            PARITY: begin
                if (tick) begin
                    cyc_n   = '0;
                    state_n = STOP;
                end else begin
                    cyc_n = cyc + C_ONE;
                end
            end
            STOP: begin
                if (tick) begin
                    cyc_n   = '0;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cyc_n = cyc + C_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cyc_n   = '0;
                bitc_n  = '0;
            end
        endcase
    end

    // Line level decoded from the registered state; idle and unknown states drive 1
    always_comb begin
        x_out = 1'b1;
        case (state)
            START:   x_out = 1'b0;
            DATA:    x_out = sh[0];
            PARITY:  x_out = par;
            default: x_out = 1'b1;
        endcase
    end

    assign bus.ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = done_q;

endmodule
